chimera_clu_pwr_seq: RTL and testbench
======================================

Name: chimera_clu_pwr_seq

Overview:
Per-cluster power/isolation sequencer for the cluster domain. It generalises the fixed per-cluster isolate request/ack pairing into a parametrised controller for N clusters with M isolation ports each. Each cluster gets an FSM that orders isolation, reset and clock gating on power-down, and the reverse on power-up, with an ack timeout. It sits in the SoC clock domain and drives the isolate inputs, clock enables and cluster resets of the cluster domain.

Parameters:
NumClusters, 5, number of independently sequenced clusters (>=1)
NumIsoPorts, 4, isolation acks per cluster (narrow in, 2x narrow out, wide) (>=1)
RstCycles, 8, cycles the cluster reset is held with clock running on wake (>=1)
SettleCycles, 4, cycles the clock keeps running under reset before gating (>=1)
TimeoutCycles, 1024, max cycles waiting for isolation acks; 0 disables timeout
CntWidth, derived, $clog2(max(RstCycles,SettleCycles,TimeoutCycles)+1)

Ports:
clk_i  in  1  SoC clock
rst_i  in  1  reset, asynchronous, active-high
power_en_i  in  NumClusters  level request per cluster: 1 = powered, 0 = off
iso_ack_i  in  NumClusters*NumIsoPorts  isolated status; cluster c uses [c*NumIsoPorts +: NumIsoPorts]
timeout_clr_i  in  NumClusters  clears sticky timeout flag
isolate_o  out  NumClusters  isolation request to the cluster's AXI isolators
clk_en_o  out  NumClusters  cluster clock gate enable
clu_rst_no  out  NumClusters  cluster reset, active-low
powered_o  out  NumClusters  1 iff the cluster FSM is in ACTIVE
timeout_o  out  NumClusters  sticky ack-timeout flag
busy_o  out  1  OR over clusters of state not in {OFF, ACTIVE}

Behaviour:
- Only clk_i and rst_i are global; all else is replicated per cluster. All outputs are registered/Moore, decoded from state.
- On rst_i: every FSM is in OFF, counter 0. isolate_o=1, clk_en_o=0, clu_rst_no=0, powered_o=0, timeout_o=0, busy_o=0.
- State outputs (isolate, clk_en, rst_n):
  - OFF (1,0,0)
  - WAKE (1,1,0)
  - DEISO (0,1,1)
  - ACTIVE (0,1,1)
  - ISO (1,1,1)
  - GATE (1,1,0)
- Per-cluster counter resets to 0 on every state entry and increments each cycle while in WAKE, GATE, ISO or DEISO. It saturates at all-ones.
- OFF: power_en_i=1 -> WAKE.
- WAKE: stays exactly RstCycles cycles -> DEISO.
- DEISO: leaves when all acks of the cluster are 0 -> ACTIVE. If the counter reaches TimeoutCycles (and TimeoutCycles != 0), set timeout_o and keep waiting.
- ACTIVE: power_en_i=0 -> ISO.
- ISO: all acks 1 -> GATE. If power_en_i returns to 1 before the acks complete -> DEISO (abort). If the counter reaches TimeoutCycles (and TimeoutCycles != 0): set timeout_o and force -> GATE. Abort has priority over ack; ack has priority over timeout.
- GATE: stays exactly SettleCycles cycles -> OFF. power_en_i is ignored.
- power_en_i is sampled only in OFF, ACTIVE and ISO. WAKE, DEISO and GATE always run to completion.
- timeout_o: set and clear in the same cycle -> set wins. Otherwise timeout_clr_i clears it on the next edge.
- Clusters are fully independent. Simultaneous transitions on different clusters do not interact.
- rst_i asserted mid-sequence: the FSM goes immediately to OFF with OFF outputs. There is no partial-sequence resume.
- Elaboration assertions: NumIsoPorts>=1, RstCycles>=1, SettleCycles>=1, and CntWidth covers TimeoutCycles.

Test Plan:
- Reset, power_en_i=0: all clusters OFF; isolate_o=all 1, clk_en_o=0, clu_rst_no=0, busy_o=0.
- Wake, cluster 0: power_en_i[0] rises before edge 0; acks follow isolate_o with 1-cycle lag (RstCycles=8).
  - clk_en_o[0]=1 after edge 0.
  - clu_rst_no[0]=1 and isolate_o[0]=0 after edge 8.
  - powered_o[0]=1 after edge 10.
  - busy_o=1 for edges 0..9.
  - Other clusters stay OFF.
- Power-down, cluster 1 (SettleCycles=4): acks rise 3 cycles after isolate_o.
  - isolate_o[1]=1 one edge after power_en_i[1] falls.
  - clu_rst_no[1]=0 three edges later.
  - clk_en_o[1]=0 four edges after that.
  - powered_o[1]=0 from ISO entry onward.
- Abort: power_en_i[2] drops then re-rises while in ISO with one ack stuck 0 -> DEISO, clu_rst_no[2] never deasserts (stays 1), ACTIVE once acks clear, timeout_o[2]=0.
- Timeout (TimeoutCycles=16): one ack of cluster 3 held 0 during power-down.
  - timeout_o[3]=1 after 16 cycles in ISO, then forced GATE then OFF.
  - Asserting timeout_clr_i[3] clears the flag one edge later.
  - Asserting it in the same cycle as a new timeout keeps the flag 1.
- Mid-WAKE reset: rst_i pulsed at WAKE cycle 3 -> outputs return to OFF values asynchronously; after release with power_en_i=1 the full RstCycles wake restarts from 0.

Source files
------------

// File: rtl/chimera_clu_pwr_seq_if.sv
// rtl/chimera_clu_pwr_seq_if.sv - request/status bundle between SoC power control and the cluster sequencer
// master = SoC-side requester, slave = sequencer.

interface chimera_clu_pwr_seq_if #(
  parameter int NumClusters = 5,
  parameter int NumIsoPorts = 4
);
  logic [NumClusters-1:0]             power_en_i;
  logic [NumClusters*NumIsoPorts-1:0] iso_ack_i;
  logic [NumClusters-1:0]             timeout_clr_i;
  logic [NumClusters-1:0]             isolate_o;
  logic [NumClusters-1:0]             clk_en_o;
  logic [NumClusters-1:0]             clu_rst_no;
  logic [NumClusters-1:0]             powered_o;
  logic [NumClusters-1:0]             timeout_o;
  logic                               busy_o;

  modport master (
    output power_en_i, iso_ack_i, timeout_clr_i,
    input  isolate_o, clk_en_o, clu_rst_no, powered_o, timeout_o, busy_o
  );

  modport slave (
    input  power_en_i, iso_ack_i, timeout_clr_i,
    output isolate_o, clk_en_o, clu_rst_no, powered_o, timeout_o, busy_o
  );
endinterface

// File: rtl/chimera_clu_pwr_seq.sv
// rtl/chimera_clu_pwr_seq.sv - per-cluster isolation/reset/clock-gate power sequencer
// One independent Moore FSM per cluster; all outputs are registered from the next state.

module chimera_clu_pwr_seq #(
  parameter int NumClusters   = 5,
  parameter int NumIsoPorts   = 4,
  parameter int RstCycles     = 8,
  parameter int SettleCycles  = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  chimera_clu_pwr_seq_if.slave        bus
);

  localparam int MaxRs     = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
  localparam int MaxCycles = (MaxRs > TimeoutCycles) ? MaxRs : TimeoutCycles;
  localparam int CntWidth  = $clog2(MaxCycles + 1);

  localparam bit                  TimeoutEn  = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] RstLast    = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] SettleLast = CntWidth'(SettleCycles - 1);
  localparam logic [CntWidth-1:0] ToLast     = CntWidth'(TimeoutEn ? TimeoutCycles - 1 : 0);
  localparam logic [CntWidth-1:0] CntMax     = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);

  if (NumClusters < 1) begin : g_bad_clusters
    $error("NumClusters must be >= 1");
  end
  if (NumIsoPorts < 1) begin : g_bad_iso_ports
    $error("NumIsoPorts must be >= 1");
  end
  if (RstCycles < 1) begin : g_bad_rst_cycles
    $error("RstCycles must be >= 1");
  end
  if (SettleCycles < 1) begin : g_bad_settle_cycles
    $error("SettleCycles must be >= 1");
  end
  if ((2 ** CntWidth) - 1 < TimeoutCycles) begin : g_bad_cnt_width
    $error("CntWidth does not cover TimeoutCycles");
  end

  typedef enum logic [2:0] {
    S_OFF,
    S_WAKE,
    S_DEISO,
    S_ACTIVE,
    S_ISO,
    S_GATE
  } state_e;

  state_e              state_q [NumClusters];
  state_e              state_d [NumClusters];
  logic [CntWidth-1:0] cnt_q   [NumClusters];
  logic [CntWidth-1:0] cnt_d   [NumClusters];

  logic [NumClusters-1:0] isolate_q, isolate_d;
  logic [NumClusters-1:0] clk_en_q, clk_en_d;
  logic [NumClusters-1:0] rst_n_q, rst_n_d;
  logic [NumClusters-1:0] powered_q, powered_d;
  logic [NumClusters-1:0] timeout_q, timeout_d;
  logic                   busy_q, busy_d;

  logic [NumClusters-1:0] ack_all;
  logic [NumClusters-1:0] ack_none;
  logic [NumClusters-1:0] to_hit;
  logic [NumClusters-1:0] to_set;
  logic [NumClusters-1:0] counting;

  always_comb begin
    ack_all   = '0;
    ack_none  = '0;
    to_hit    = '0;
    to_set    = '0;
    counting  = '0;
    isolate_d = '0;
    clk_en_d  = '0;
    rst_n_d   = '0;
    powered_d = '0;
    timeout_d = '0;
    busy_d    = 1'b0;
    for (int c = 0; c < NumClusters; c++) begin
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      ack_all[c]  = &bus.iso_ack_i[c*NumIsoPorts +: NumIsoPorts];
      ack_none[c] = ~|bus.iso_ack_i[c*NumIsoPorts +: NumIsoPorts];
      // Fires on the edge where the counter would reach TimeoutCycles; saturation never re-arms it.
      to_hit[c]   = TimeoutEn && (cnt_q[c] == ToLast);

      unique case (state_q[c])
        S_OFF: begin
          if (bus.power_en_i[c]) state_d[c] = S_WAKE;
        end
        S_WAKE: begin
          if (cnt_q[c] == RstLast) state_d[c] = S_DEISO;
        end
        S_DEISO: begin
          if (ack_none[c]) begin
            state_d[c] = S_ACTIVE;
          end else if (to_hit[c]) begin
            to_set[c] = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!bus.power_en_i[c]) state_d[c] = S_ISO;
        end
        S_ISO: begin
          if (bus.power_en_i[c]) begin
            state_d[c] = S_DEISO;
          end else if (ack_all[c]) begin
            state_d[c] = S_GATE;
          end else if (to_hit[c]) begin
            to_set[c]  = 1'b1;
            state_d[c] = S_GATE;
          end
        end
        S_GATE: begin
          if (cnt_q[c] == SettleLast) state_d[c] = S_OFF;
        end
        default: state_d[c] = S_OFF;
      endcase

      counting[c] = state_q[c] inside {S_WAKE, S_DEISO, S_ISO, S_GATE};
      if (state_d[c] != state_q[c]) begin
        cnt_d[c] = '0;
      end else if (counting[c] && (cnt_q[c] != CntMax)) begin
        cnt_d[c] = cnt_q[c] + CntOne;
      end

      isolate_d[c] = state_d[c] inside {S_OFF, S_WAKE, S_ISO, S_GATE};
      clk_en_d[c]  = (state_d[c] != S_OFF);
      rst_n_d[c]   = state_d[c] inside {S_DEISO, S_ACTIVE, S_ISO};
      powered_d[c] = (state_d[c] == S_ACTIVE);
      timeout_d[c] = to_set[c] | (timeout_q[c] & ~bus.timeout_clr_i[c]);
      if (!(state_d[c] inside {S_OFF, S_ACTIVE})) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumClusters; c++) begin
        state_q[c] <= S_OFF;
        cnt_q[c]   <= '0;
      end
      isolate_q <= '1;
      clk_en_q  <= '0;
      rst_n_q   <= '0;
      powered_q <= '0;
      timeout_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isolate_q <= isolate_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      powered_q <= powered_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.isolate_o  = isolate_q;
  assign bus.clk_en_o   = clk_en_q;
  assign bus.clu_rst_no = rst_n_q;
  assign bus.powered_o  = powered_q;
  assign bus.timeout_o  = timeout_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// tb/tb_chimera_clu_pwr_seq.sv - directed plus randomized check of the cluster power sequencer
// A phase/elapsed-time model predicts every output each cycle; literal checks pin the model.

module tb_chimera_clu_pwr_seq;
  localparam int NC = 5;
  localparam int NP = 4;
  localparam int RC = 8;
  localparam int SC = 4;
  localparam int TC = 16;

  localparam int P_OFF    = 0;
  localparam int P_WAKE   = 1;
  localparam int P_DEISO  = 2;
  localparam int P_ACTIVE = 3;
  localparam int P_ISO    = 4;
  localparam int P_GATE   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chimera_clu_pwr_seq_if #(.NumClusters(NC), .NumIsoPorts(NP)) bus ();

  chimera_clu_pwr_seq #(
    .NumClusters  (NC),
    .NumIsoPorts  (NP),
    .RstCycles    (RC),
    .SettleCycles (SC),
    .TimeoutCycles(TC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase and elapsed cycles in that phase per cluster.
  int         ph    [NC];
  int         el    [NC];
  int         m_nph [NC];
  logic [NC-1:0] m_tset;
  logic [NC-1:0] m_to;

  function automatic int step_phase(input int p, input int e, input logic pen,
                                    input logic [NP-1:0] a, output bit ts);
    bit lim;
    ts  = 1'b0;
    lim = (TC != 0) && (e + 1 == TC);
    step_phase = p;
    case (p)
      P_OFF:    if (pen) step_phase = P_WAKE;
      P_WAKE:   if (e + 1 == RC) step_phase = P_DEISO;
      P_DEISO:  if (a == '0) step_phase = P_ACTIVE; else if (lim) ts = 1'b1;
      P_ACTIVE: if (!pen) step_phase = P_ISO;
      P_ISO: begin
        if (pen) step_phase = P_DEISO;
        else if (&a) step_phase = P_GATE;
        else if (lim) begin ts = 1'b1; step_phase = P_GATE; end
      end
      P_GATE:   if (e + 1 == SC) step_phase = P_OFF;
      default:  step_phase = P_OFF;
    endcase
  endfunction

  always_comb begin
    m_tset = '0;
    m_nph  = '{default: 0};
    for (int c = 0; c < NC; c++) begin
      bit ts;
      m_nph[c]  = step_phase(ph[c], el[c], bus.power_en_i[c], bus.iso_ack_i[c*NP +: NP], ts);
      m_tset[c] = ts;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        ph[c] <= P_OFF;
        el[c] <= 0;
      end
      m_to <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        ph[c]   <= m_nph[c];
        el[c]   <= (m_nph[c] != ph[c]) ? 0 : el[c] + 1;
        m_to[c] <= m_tset[c] | (m_to[c] & ~bus.timeout_clr_i[c]);
      end
    end
  end

  logic [NC-1:0] e_iso, e_ce, e_rn, e_pw;
  logic          e_busy;
  always_comb begin
    e_iso  = '0;
    e_ce   = '0;
    e_rn   = '0;
    e_pw   = '0;
    e_busy = 1'b0;
    for (int c = 0; c < NC; c++) begin
      e_iso[c] = (ph[c] == P_OFF) || (ph[c] == P_WAKE) || (ph[c] == P_ISO) || (ph[c] == P_GATE);
      e_ce[c]  = (ph[c] != P_OFF);
      e_rn[c]  = (ph[c] == P_DEISO) || (ph[c] == P_ACTIVE) || (ph[c] == P_ISO);
      e_pw[c]  = (ph[c] == P_ACTIVE);
      if ((ph[c] != P_OFF) && (ph[c] != P_ACTIVE)) e_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("isolate_o",  bus.isolate_o,  e_iso);
      chk("clk_en_o",   bus.clk_en_o,   e_ce);
      chk("clu_rst_no", bus.clu_rst_no, e_rn);
      chk("powered_o",  bus.powered_o,  e_pw);
      chk("timeout_o",  bus.timeout_o,  m_to);
      chk("busy_o",     bus.busy_o,     e_busy);
    end
  end

  // Ack emulation: each port follows isolate_o after lag observations, unless stuck.
  int            lag  [NC];
  int            pend [NC*NP];
  logic [NC*NP-1:0] stuck0, stuck1;

  task automatic upd_acks();
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NP; p++) begin
        int   i;
        logic want;
        i    = c * NP + p;
        want = stuck0[i] ? 1'b0 : (stuck1[i] ? 1'b1 : bus.isolate_o[c]);
        if (bus.iso_ack_i[i] == want) begin
          pend[i] = 0;
        end else begin
          pend[i]++;
          if (pend[i] >= lag[c]) begin
            bus.iso_ack_i[i] = want;
            pend[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      upd_acks();
    end
  endtask

  initial begin
    bus.power_en_i    = '0;
    bus.iso_ack_i     = '1;
    bus.timeout_clr_i = '0;
    stuck0 = '0;
    stuck1 = '0;
    for (int c = 0; c < NC; c++) lag[c] = 2;
    for (int i = 0; i < NC*NP; i++) pend[i] = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_isolate", bus.isolate_o, 5'h1f);
    chk("rst_clk_en", bus.clk_en_o, 5'h00);
    chk("rst_rst_n", bus.clu_rst_no, 5'h00);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_timeout", bus.timeout_o, 5'h00);
    rst = 1'b0;

    // Wake cluster 0.
    bus.power_en_i[0] = 1'b1;
    cyc(1);
    chk("wake0_clk_en", bus.clk_en_o[0], 1'b1);
    chk("wake0_rst_n_e0", bus.clu_rst_no[0], 1'b0);
    chk("wake0_busy_e0", bus.busy_o, 1'b1);
    cyc(7);
    chk("wake0_rst_n_e7", bus.clu_rst_no[0], 1'b0);
    cyc(1);
    chk("wake0_rst_n_e8", bus.clu_rst_no[0], 1'b1);
    chk("wake0_iso_e8", bus.isolate_o[0], 1'b0);
    chk("wake0_others_iso", bus.isolate_o[4:1], 4'hf);
    chk("wake0_others_ce", bus.clk_en_o[4:1], 4'h0);
    cyc(1);
    chk("wake0_pw_e9", bus.powered_o[0], 1'b0);
    chk("wake0_busy_e9", bus.busy_o, 1'b1);
    cyc(1);
    chk("wake0_pw_e10", bus.powered_o[0], 1'b1);
    chk("wake0_busy_e10", bus.busy_o, 1'b0);

    bus.power_en_i[3:1] = 3'b111;
    cyc(14);
    chk("up123_powered", bus.powered_o, 5'h0f);

    // Power-down cluster 1 with acks rising 3 cycles after isolate.
    lag[1] = 3;
    bus.power_en_i[1] = 1'b0;
    cyc(1);
    chk("dn1_iso", bus.isolate_o[1], 1'b1);
    chk("dn1_pw", bus.powered_o[1], 1'b0);
    cyc(2);
    chk("dn1_rst_n_held", bus.clu_rst_no[1], 1'b1);
    cyc(1);
    chk("dn1_rst_n_low", bus.clu_rst_no[1], 1'b0);
    chk("dn1_ce_gate", bus.clk_en_o[1], 1'b1);
    cyc(3);
    chk("dn1_ce_settle", bus.clk_en_o[1], 1'b1);
    cyc(1);
    chk("dn1_ce_off", bus.clk_en_o[1], 1'b0);

    // Abort on cluster 2 with one ack stuck low.
    stuck0[2*NP] = 1'b1;
    bus.power_en_i[2] = 1'b0;
    cyc(3);
    bus.power_en_i[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("abort2_rst_n", bus.clu_rst_no[2], 1'b1);
    end
    chk("abort2_pw", bus.powered_o[2], 1'b1);
    chk("abort2_to", bus.timeout_o[2], 1'b0);
    stuck0 = '0;

    // Timeout on cluster 3.
    lag[3] = 3;
    stuck0[3*NP+1] = 1'b1;
    bus.power_en_i[3] = 1'b0;
    cyc(16);
    chk("to3_before", bus.timeout_o[3], 1'b0);
    chk("to3_iso_rst_n", bus.clu_rst_no[3], 1'b1);
    cyc(1);
    chk("to3_set", bus.timeout_o[3], 1'b1);
    chk("to3_gate_rst_n", bus.clu_rst_no[3], 1'b0);
    cyc(3);
    chk("to3_gate_ce", bus.clk_en_o[3], 1'b1);
    cyc(1);
    chk("to3_off_ce", bus.clk_en_o[3], 1'b0);
    bus.timeout_clr_i[3] = 1'b1;
    cyc(1);
    bus.timeout_clr_i[3] = 1'b0;
    chk("to3_cleared", bus.timeout_o[3], 1'b0);

    bus.power_en_i[3] = 1'b1;
    cyc(16);
    chk("to3_reup", bus.powered_o[3], 1'b1);
    bus.power_en_i[3] = 1'b0;
    cyc(16);
    chk("to3_again_before", bus.timeout_o[3], 1'b0);
    bus.timeout_clr_i[3] = 1'b1;
    cyc(1);
    bus.timeout_clr_i[3] = 1'b0;
    chk("to3_set_wins", bus.timeout_o[3], 1'b1);
    cyc(4);
    bus.timeout_clr_i[3] = 1'b1;
    cyc(1);
    bus.timeout_clr_i[3] = 1'b0;
    chk("to3_cleared2", bus.timeout_o[3], 1'b0);
    stuck0 = '0;

    // Reset in the middle of the wake of cluster 4.
    bus.power_en_i[4] = 1'b1;
    cyc(4);
    chk("mid4_waking", bus.clk_en_o[4], 1'b1);
    rst = 1'b1;
    #1;
    chk("mid4_rst_iso", bus.isolate_o, 5'h1f);
    chk("mid4_rst_ce", bus.clk_en_o, 5'h00);
    chk("mid4_rst_rst_n", bus.clu_rst_no, 5'h00);
    chk("mid4_rst_pw", bus.powered_o, 5'h00);
    chk("mid4_rst_busy", bus.busy_o, 1'b0);
    #1;
    rst = 1'b0;
    cyc(1);
    chk("mid4_rewake_ce", bus.clk_en_o[4], 1'b1);
    chk("mid4_rewake_rst_n0", bus.clu_rst_no[4], 1'b0);
    cyc(7);
    chk("mid4_rewake_rst_n7", bus.clu_rst_no[4], 1'b0);
    cyc(1);
    chk("mid4_rewake_rst_n8", bus.clu_rst_no[4], 1'b1);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NC; c++) begin
        int k;
        if ($urandom_range(39) == 0) bus.power_en_i[c] = ~bus.power_en_i[c];
        if ($urandom_range(59) == 0) lag[c] = $urandom_range(5, 1);
        k = c * NP + int'($urandom_range(NP - 1));
        if ($urandom_range(99) == 0) stuck0[k] = ~stuck0[k];
        k = c * NP + int'($urandom_range(NP - 1));
        if ($urandom_range(99) == 0) stuck1[k] = ~stuck1[k];
        if ($urandom_range(149) == 0) begin
          stuck0[c*NP +: NP] = '0;
          stuck1[c*NP +: NP] = '0;
        end
        bus.timeout_clr_i[c] = ($urandom_range(24) == 0);
      end
      cyc(1);
    end

    bus.timeout_clr_i = '0;
    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
